// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: MD funct codes, FSM states
// and datapath mode.
package md_pkg;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } md_mode_e;

   function automatic logic is_md_funct(input logic [5:0] f);
      return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                       F_MULT, F_MULTU, F_DIV, F_DIVU};
   endfunction

endpackage

// File: rtl/md_if.sv
// EX-stage connection between the pipeline and the multiply/divide unit.
interface md_if #(
   parameter int WIDTH = 32
) ();

   logic             start;
   logic [5:0]       funct;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             stall;
   logic [WIDTH-1:0] rdata;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             illegal;

   modport master (
      output start, funct, a, b, flush,
      input  stall, rdata, hi, lo, busy, done, illegal
   );

   modport slave (
      input  start, funct, a, b, flush,
      output stall, rdata, hi, lo, busy, done, illegal
   );

endinterface

// File: rtl/md_iter.sv
// One radix-2 step on the {rem, q} register pair: shift-add for multiply,
// restoring shift-subtract for divide.
module md_iter
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  md_mode_e         mode_i,
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      rem_o   = rem_i;
      q_o     = q_i;
      sum     = {1'b0, rem_i} + {1'b0, opnd_i};
      shifted = {rem_i, q_i[WIDTH-1]};
      diff    = shifted - {1'b0, opnd_i};
      if (mode_i == MODE_MUL) begin
         if (q_i[0]) {rem_o, q_o} = {sum, q_i[WIDTH-1:1]};
         else        {rem_o, q_o} = {1'b0, rem_i, q_i[WIDTH-1:1]};
      end else begin
         // A borrow out of the trial subtraction means the divisor did not fit.
         if (!diff[WIDTH]) begin
            rem_o = diff[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b1};
         end else begin
            rem_o = shifted[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/md_unit.sv
// Sequential multiply/divide unit with architectural HI/LO registers; decodes
// the MD functs, iterates on magnitudes and applies the sign fix-up at the end.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic clk,
   input logic reset_n,
   md_if.slave md
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   md_state_e        state_q;
   md_mode_e         mode_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [WIDTH-1:0] acc_q, q_q, opnd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_q_q, neg_r_q, div0_q;
   logic             busy_q, done_q, illegal_q;

   logic             is_md, is_arith, is_mul, is_signed, sign_a, sign_b;
   logic [WIDTH-1:0] a_abs, b_abs, iter_rem, iter_q;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] fix_hi_d, fix_lo_d;

   always_comb begin
      is_md     = is_md_funct(md.funct);
      is_mul    = (md.funct == F_MULT) || (md.funct == F_MULTU);
      is_arith  = is_mul || (md.funct == F_DIV) || (md.funct == F_DIVU);
      is_signed = (md.funct == F_MULT) || (md.funct == F_DIV);
      sign_a    = is_signed && md.a[WIDTH-1];
      sign_b    = is_signed && md.b[WIDTH-1];
      a_abs     = sign_a ? -md.a : md.a;
      b_abs     = sign_b ? -md.b : md.b;
   end

   md_iter #(.WIDTH(WIDTH)) u_iter (
      .mode_i (mode_q),
      .rem_i  (acc_q),
      .q_i    (q_q),
      .opnd_i (opnd_q),
      .rem_o  (iter_rem),
      .q_o    (iter_q)
   );

   // The most negative dividend over -1 needs no special case: its magnitude
   // fits unsigned and negating it wraps back onto itself.
   always_comb begin
      prod = {acc_q, q_q};
      if (mode_q == MODE_MUL) begin
         {fix_hi_d, fix_lo_d} = neg_q_q ? -prod : prod;
      end else begin
         fix_hi_d = neg_r_q ? -acc_q : acc_q;
         fix_lo_d = div0_q ? '1 : (neg_q_q ? -q_q : q_q);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_MUL;
         hi_q      <= '0;
         lo_q      <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         opnd_q    <= '0;
         cnt_q     <= '0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
         div0_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         illegal_q <= md.start && !md.flush && !is_md;
         if (md.flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (md.start && is_md) begin
                     if (md.funct == F_MTHI) hi_q <= md.a;
                     if (md.funct == F_MTLO) lo_q <= md.a;
                     if (is_arith) begin
                        mode_q  <= is_mul ? MODE_MUL : MODE_DIV;
                        acc_q   <= '0;
                        q_q     <= is_mul ? b_abs : a_abs;
                        opnd_q  <= is_mul ? a_abs : b_abs;
                        neg_q_q <= sign_a ^ sign_b;
                        neg_r_q <= sign_a;
                        div0_q  <= !is_mul && (md.b == '0);
                        cnt_q   <= CNT_W'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                     end
                  end
               end
               ST_CALC: begin
                  acc_q <= iter_rem;
                  q_q   <= iter_q;
                  if (cnt_q == '0) state_q <= ST_FIX;
                  else             cnt_q   <= cnt_q - 1'b1;
               end
               ST_FIX: begin
                  hi_q    <= fix_hi_d;
                  lo_q    <= fix_lo_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign md.stall   = md.start && is_md && (busy_q || (state_q != ST_IDLE));
   assign md.rdata   = (md.funct == F_MFHI) ? hi_q : lo_q;
   assign md.hi      = hi_q;
   assign md.lo      = lo_q;
   assign md.busy    = busy_q;
   assign md.done    = done_q;
   assign md.illegal = illegal_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit at WIDTH=32: arithmetic results, latency, stall,
// flush, asynchronous reset and illegal-funct behaviour.
module tb_md_unit;
   import md_pkg::*;

   localparam logic [5:0] F_NONMD = 6'b101010;
   localparam logic [5:0] F_IDLE  = 6'b100000;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   failures = 0;

   md_if #(.WIDTH(32)) bus ();

   md_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .md      (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issues one MULT*/DIV* op in the current cycle t and returns in the done
   // cycle (or after the budget) with the number of cycles elapsed since t.
   task automatic run_op(input logic [5:0] f, input logic [31:0] aa, input logic [31:0] bb,
                         output int lat, output logic busy1);
      bus.start = 1'b1;
      bus.funct = f;
      bus.a     = aa;
      bus.b     = bb;
      next_cycle();
      bus.start = 1'b0;
      bus.funct = F_IDLE;
      busy1 = bus.busy;
      lat = 1;
      while (bus.done !== 1'b1 && lat < 60) begin
         next_cycle();
         lat++;
      end
   endtask

   task automatic test_reset();
      checks++;
      if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
         failures++;
         $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", bus.hi, bus.lo);
      end
      checks++;
      if ({bus.busy, bus.done, bus.illegal, bus.stall} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: busy/done/illegal/stall=%b expected 0000",
                  {bus.busy, bus.done, bus.illegal, bus.stall});
      end
   endtask

   task automatic test_mult();
      int   lat;
      logic busy1;
      bus.start = 1'b1; bus.funct = F_MULT; bus.a = 32'hFFFFFFFD; bus.b = 32'd7;
      #1;
      checks++;
      if (bus.stall !== 1'b0) begin
         failures++;
         $display("FAIL mult_idle_stall: stall=%b expected 0", bus.stall);
      end
      run_op(F_MULT, 32'hFFFFFFFD, 32'd7, lat, busy1);
      checks++;
      if (busy1 !== 1'b1) begin
         failures++;
         $display("FAIL mult_busy_t1: busy=%b expected 1", busy1);
      end
      checks++;
      if (lat != 34) begin
         failures++;
         $display("FAIL mult_latency: done after %0d cycles expected 34", lat);
      end
      checks++;
      if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFEB || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL mult_neg3x7: hi=%h lo=%h busy=%b expected FFFFFFFF FFFFFFEB 0",
                  bus.hi, bus.lo, bus.busy);
      end
      next_cycle();
      checks++;
      if (bus.done !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse: done=%b one cycle later expected 0", bus.done);
      end
      run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busy1);
      checks++;
      if (lat != 34 || bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001) begin
         failures++;
         $display("FAIL multu_max: lat=%0d hi=%h lo=%h expected 34 FFFFFFFE 00000001",
                  lat, bus.hi, bus.lo);
      end
      next_cycle();
   endtask

   task automatic test_div();
      int   lat;
      logic busy1;
      logic [5:0]  f_t   [5] = '{F_DIV, F_DIVU, F_DIV, F_DIV, F_DIV};
      logic [31:0] a_t   [5] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd7, 32'hFFFFFFFB};
      logic [31:0] b_t   [5] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0};
      logic [31:0] hi_t  [5] = '{32'hFFFFFFFF, 32'd7, 32'd0, 32'd1, 32'hFFFFFFFB};
      logic [31:0] lo_t  [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
                                 32'hFFFFFFFD, 32'hFFFFFFFF};
      for (int i = 0; i < 5; i++) begin
         run_op(f_t[i], a_t[i], b_t[i], lat, busy1);
         checks++;
         if (lat != 34 || bus.hi !== hi_t[i] || bus.lo !== lo_t[i]) begin
            failures++;
            $display("FAIL div_vec%0d: lat=%0d hi=%h lo=%h expected 34 %h %h",
                     i, lat, bus.hi, bus.lo, hi_t[i], lo_t[i]);
         end
         next_cycle();
      end
   endtask

   task automatic test_stall();
      int bad;
      int n;
      bus.start = 1'b1; bus.funct = F_DIVU; bus.a = 32'd100; bus.b = 32'd7;
      next_cycle();
      bus.funct = F_MFLO;
      #1;
      bad = 0;
      for (int k = 1; k <= 33; k++) begin
         if (bus.stall !== 1'b1) bad++;
         next_cycle();
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL mflo_stall_window: %0d cycles without stall expected 0", bad);
      end
      checks++;
      if (bus.stall !== 1'b0 || bus.rdata !== 32'd14 || bus.done !== 1'b1) begin
         failures++;
         $display("FAIL mflo_done_cycle: stall=%b rdata=%0d done=%b expected 0 14 1",
                  bus.stall, bus.rdata, bus.done);
      end
      bus.start = 1'b0;
      bus.funct = F_MFHI;
      #1;
      checks++;
      if (bus.rdata !== 32'd2) begin
         failures++;
         $display("FAIL mfhi_rdata: rdata=%0d expected 2", bus.rdata);
      end
      next_cycle();
      // MTHI held during an op must wait for the done cycle.
      bus.start = 1'b1; bus.funct = F_DIVU; bus.a = 32'd100; bus.b = 32'd7;
      next_cycle();
      bus.funct = F_MTHI;
      bus.a = 32'hCAFEF00D;
      #1;
      n = 0;
      while (bus.stall === 1'b1 && n < 60) begin
         n++;
         next_cycle();
      end
      checks++;
      if (n != 33 || bus.hi !== 32'd2 || bus.done !== 1'b1) begin
         failures++;
         $display("FAIL mthi_wait: stall_cycles=%0d hi=%h done=%b expected 33 00000002 1",
                  n, bus.hi, bus.done);
      end
      next_cycle();
      bus.start = 1'b0;
      bus.funct = F_IDLE;
      checks++;
      if (bus.hi !== 32'hCAFEF00D || bus.lo !== 32'd14) begin
         failures++;
         $display("FAIL mthi_after_done: hi=%h lo=%h expected CAFEF00D 0000000E",
                  bus.hi, bus.lo);
      end
   endtask

   task automatic test_flush();
      int dones;
      bus.start = 1'b1; bus.funct = F_MTHI; bus.a = 32'h55;
      next_cycle();
      bus.funct = F_MTLO;
      next_cycle();
      // start and flush together: the start is dropped
      bus.funct = F_DIV; bus.a = 32'd9; bus.b = 32'd3; bus.flush = 1'b1;
      next_cycle();
      bus.start = 1'b0; bus.flush = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.hi !== 32'h55 || bus.lo !== 32'h55) begin
         failures++;
         $display("FAIL start_with_flush: busy=%b hi=%h lo=%h expected 0 55 55",
                  bus.busy, bus.hi, bus.lo);
      end
      // flush in the middle of CALC
      bus.start = 1'b1; bus.funct = F_DIV; bus.a = 32'd1000; bus.b = 32'd3;
      next_cycle();
      bus.start = 1'b0;
      repeat (9) next_cycle();
      bus.flush = 1'b1;
      next_cycle();
      bus.flush = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL flush_busy: busy=%b at t+11 expected 0", bus.busy);
      end
      dones = 0;
      repeat (40) begin
         if (bus.done === 1'b1) dones++;
         next_cycle();
      end
      checks++;
      if (dones != 0 || bus.hi !== 32'h55 || bus.lo !== 32'h55) begin
         failures++;
         $display("FAIL flush_calc: dones=%0d hi=%h lo=%h expected 0 55 55",
                  dones, bus.hi, bus.lo);
      end
      // flush during the FIX cycle suppresses the HI/LO write
      bus.start = 1'b1; bus.funct = F_DIVU; bus.a = 32'd100; bus.b = 32'd7;
      next_cycle();
      bus.start = 1'b0;
      repeat (32) next_cycle();
      bus.flush = 1'b1;
      next_cycle();
      bus.flush = 1'b0;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== 32'h55 || bus.lo !== 32'h55) begin
         failures++;
         $display("FAIL flush_fix: done=%b busy=%b hi=%h lo=%h expected 0 0 55 55",
                  bus.done, bus.busy, bus.hi, bus.lo);
      end
   endtask

   task automatic test_reset_mid_op();
      int   lat;
      logic busy1;
      bus.start = 1'b1; bus.funct = F_MTHI; bus.a = 32'hAAAA;
      next_cycle();
      bus.funct = F_MTLO; bus.a = 32'hBBBB;
      next_cycle();
      bus.funct = F_MULT; bus.a = 32'd5; bus.b = 32'd6;
      next_cycle();
      bus.start = 1'b0;
      repeat (4) next_cycle();
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: hi=%h lo=%h busy=%b expected 0 0 0",
                  bus.hi, bus.lo, bus.busy);
      end
      #3 reset_n = 1'b1;
      next_cycle();
      run_op(F_MULT, 32'd5, 32'd6, lat, busy1);
      checks++;
      if (lat != 34 || bus.hi !== 32'h0 || bus.lo !== 32'd30) begin
         failures++;
         $display("FAIL mult_after_reset: lat=%0d hi=%h lo=%h expected 34 0 1E",
                  lat, bus.hi, bus.lo);
      end
      next_cycle();
   endtask

   task automatic test_illegal_and_mt();
      bus.start = 1'b1; bus.funct = F_NONMD; bus.a = 32'hDEAD; bus.b = 32'hBEEF;
      #1;
      checks++;
      if (bus.stall !== 1'b0) begin
         failures++;
         $display("FAIL nonmd_stall: stall=%b expected 0", bus.stall);
      end
      next_cycle();
      bus.start = 1'b0;
      bus.funct = F_IDLE;
      checks++;
      if (bus.illegal !== 1'b1 || bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'd30) begin
         failures++;
         $display("FAIL illegal_pulse: illegal=%b busy=%b hi=%h lo=%h expected 1 0 0 1E",
                  bus.illegal, bus.busy, bus.hi, bus.lo);
      end
      next_cycle();
      checks++;
      if (bus.illegal !== 1'b0) begin
         failures++;
         $display("FAIL illegal_clear: illegal=%b expected 0", bus.illegal);
      end
      bus.start = 1'b1; bus.funct = F_MTLO; bus.a = 32'h1234;
      next_cycle();
      bus.start = 1'b0;
      bus.funct = F_IDLE;
      checks++;
      if (bus.lo !== 32'h1234 || bus.hi !== 32'h0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL mtlo: lo=%h hi=%h done=%b busy=%b expected 1234 0 0 0",
                  bus.lo, bus.hi, bus.done, bus.busy);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      bus.start = 1'b0;
      bus.funct = F_IDLE;
      bus.a     = '0;
      bus.b     = '0;
      bus.flush = 1'b0;
      #2;
      test_reset();
      #20 reset_n = 1'b1;
      next_cycle();
      test_mult();
      test_div();
      test_stall();
      test_flush();
      test_reset_mid_op();
      test_illegal_and_mt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
